// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared baud divisors and receiver state type
package uart_rx_pkg;
  localparam int B115200 = 104;
  localparam int B9600 = 1250;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_e;
endpackage

// File: rtl/uart_rx_baudgen.sv
// baudgen_rx: bit-period down-counter, tick at zero, clr loads a half period
module baudgen_rx #(
  parameter int M = 104
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(M);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == '0;
  always_comb cnt_d = clr ? W'(M / 2 - 1) : tick ? W'(M - 1) : cnt_q - 1'b1;
  always_ff @(posedge clk) cnt_q <= !rstn ? '0 : cnt_d;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling and framing-error detection
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int BAUDRATE = B115200
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rcv,
  output logic       ferr
);
  logic [1:0] sync_q;
  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sr_q, sr_d, data_q, data_d;
  logic       rcv_q, rcv_d, ferr_q, ferr_d, clr, tick, rxs;
  assign rxs = sync_q[1];
  baudgen_rx #(.M(BAUDRATE)) u_baud (.clk(clk), .rstn(rstn), .clr(clr), .tick(tick));
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sr_d    = sr_q;
    data_d  = data_q;
    rcv_d   = 1'b0;
    ferr_d  = 1'b0;
    clr     = 1'b0;
    case (state_q)
      IDLE: if (!rxs) begin
        state_d = START;
        clr     = 1'b1;
      end
      START: if (tick) begin
        state_d = rxs ? IDLE : DATA;
        idx_d   = '0;
      end
      DATA: if (tick) begin
        sr_d    = {rxs, sr_q[7:1]};
        idx_d   = idx_q + 3'd1;
        state_d = idx_q == 3'd7 ? STOP : DATA;
      end
      // leaving mid-stop-bit lets a gapless next start bit be caught
      STOP: if (tick) begin
        state_d = rxs ? IDLE : BRK;
        data_d  = rxs ? sr_q : data_q;
        rcv_d   = rxs;
        ferr_d  = !rxs;
      end
      BRK: state_d = rxs ? IDLE : BRK;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      idx_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      rcv_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      state_q <= state_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      rcv_q   <= rcv_d;
      ferr_q  <= ferr_d;
    end
  end
  assign data = data_q;
  assign rcv  = rcv_q;
  assign ferr = ferr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed 8N1 frames checked against a frame-level receive model
module tb_uart_rx;
  localparam int B = 104;
  localparam int LAT = 2 + B / 2 + 9 * B;
  typedef struct {logic [7:0] b; int due;} exp_t;
  logic clk = 0, rstn = 0, rx = 1;
  logic [7:0] data;
  logic rcv, ferr;
  int cyc = 0, checks = 0, errors = 0, last_lat = 0, fd = 0;
  bit rst_edge = 0;
  logic [7:0] exp_data = 0;
  exp_t rq[$];
  exp_t e;
  int fq[$];
  int rcv_at[$];

  uart_rx #(.BAUDRATE(B)) dut (.clk(clk), .rstn(rstn), .rx(rx), .data(data), .rcv(rcv), .ferr(ferr));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_edge <= !rstn;
  end

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // every strobe must match the oldest outstanding frame, within one cycle of its due time
  always @(negedge clk) begin
    if (rst_edge) begin
      exp_data = 0;
      chk(data == 8'h00, "reset_data", data, 0);
      chk({rcv, ferr} == 2'b00, "reset_strobes", {rcv, ferr}, 0);
    end else begin
      if (rcv && ferr) chk(0, "rcv_ferr_exclusive", 1, 0);
      if (rcv) begin
        rcv_at.push_back(cyc);
        if (rq.size() == 0) chk(0, "unexpected_rcv", data, 0);
        else begin
          e = rq.pop_front();
          last_lat = cyc - (e.due - LAT);
          chk(cyc >= e.due - 1 && cyc <= e.due + 1, "rcv_latency", last_lat, LAT);
          exp_data = e.b;
        end
      end
      if (ferr) begin
        if (fq.size() == 0) chk(0, "unexpected_ferr", cyc, 0);
        else begin
          fd = fq.pop_front();
          chk(cyc >= fd - 1 && cyc <= fd + 1, "ferr_latency", cyc - (fd - LAT), LAT);
        end
      end
      chk(data == exp_data, "data_value", data, exp_data);
      if (rq.size() != 0 && cyc > rq[0].due + 1) begin
        chk(0, "missing_rcv", 0, rq[0].b);
        rq.delete(0);
      end
      if (fq.size() != 0 && cyc > fq[0] + 1) begin
        chk(0, "missing_ferr", 0, 1);
        fq.delete(0);
      end
    end
  end

  task automatic send(input logic [7:0] b, input int per = B, input bit stop = 1);
    int s = cyc;
    rx = 0;
    if (stop) rq.push_back('{b, s + LAT});
    else fq.push_back(s + LAT);
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (per) @(negedge clk);
    end
    rx = stop;
    repeat (per) @(negedge clk);
  endtask

  initial begin
    logic [7:0] r;
    @(negedge clk);
    repeat (3) @(negedge clk);
    rstn = 1;
    repeat (20) @(negedge clk);
    send(8'h41);
    chk(data == 8'h41, "lit_data_41", data, 8'h41);
    chk(last_lat >= 989 && last_lat <= 991, "lit_latency_990", last_lat, 990);
    send(8'h00);
    chk(data == 8'h00, "lit_data_00", data, 8'h00);
    send(8'hFF);
    chk(data == 8'hFF, "lit_data_ff", data, 8'hFF);
    rx = 0;
    repeat (20) @(negedge clk);
    rx = 1;
    repeat (200) @(negedge clk);
    chk(data == 8'hFF, "lit_glitch_data", data, 8'hFF);
    send(8'h55, B, 0);
    repeat (3000) @(negedge clk);
    rx = 1;
    repeat (50) @(negedge clk);
    chk(data == 8'hFF, "lit_ferr_data", data, 8'hFF);
    send(8'h3C);
    chk(data == 8'h3C, "lit_data_3c", data, 8'h3C);
    rcv_at.delete();
    send(8'hA5);
    send(8'h5A);
    send(8'hC3);
    chk(rcv_at.size() == 3, "b2b_count", rcv_at.size(), 3);
    if (rcv_at.size() == 3) begin
      chk(rcv_at[1] - rcv_at[0] == 1040, "b2b_gap1", rcv_at[1] - rcv_at[0], 1040);
      chk(rcv_at[2] - rcv_at[1] == 1040, "b2b_gap2", rcv_at[2] - rcv_at[1], 1040);
    end
    chk(data == 8'hC3, "lit_data_c3", data, 8'hC3);
    r = 8'h81;
    rx = 0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = r[i];
      repeat (B) @(negedge clk);
    end
    rx = r[4];
    repeat (B / 2) @(negedge clk);
    rstn = 0;
    @(negedge clk);
    rstn = 1;
    rx = 1;
    chk(data == 8'h00, "lit_reset_data", data, 0);
    repeat (300) @(negedge clk);
    send(8'h7E);
    chk(data == 8'h7E, "lit_data_7e", data, 8'h7E);
    rcv_at.delete();
    send(8'h96, 100);
    repeat (100) @(negedge clk);
    send(8'h96, 108);
    chk(rcv_at.size() == 2, "skew_count", rcv_at.size(), 2);
    chk(data == 8'h96, "lit_data_96", data, 8'h96);
    repeat (50) @(negedge clk);
    chk(rq.size() + fq.size() == 0, "queues_drained", rq.size() + fq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART peripheral set: it recovers 8N1 characters from an asynchronous `rx` line, idle high, LSB first. It is the downstream counterpart of the character transmitter and is driven directly by a transmitter's `tx` output in loop-back benches. Each validated byte is presented on `data` with a one-cycle `rcv` strobe. Framing errors are flagged with a one-cycle `ferr` strobe.

## Interface
- `BAUDRATE`, default `` `B115200 `` (104 at 12 MHz): clock cycles per bit; legal range ≥ 8; taken from the shared baud constants.
- `clk`  in  1: system clock, single clock domain.
- `rstn`  in  1: reset, synchronous, active-low, sampled on rising `clk`.
- `rx`  in  1: asynchronous serial input; idle level 1.
- `data`  out  8: last correctly received byte; holds its value until the next valid byte.
- `rcv`  out  1: one-cycle strobe; `data` is valid and new in that cycle.
- `ferr`  out  1: one-cycle strobe; stop bit was sampled as 0.

## Operation
- **Synchronizer:** two flip-flops on `rx` produce `rxs`. Both reset to 1. The FSM uses only `rxs`.
- **Bit counter:** counts down. It loads `BAUDRATE/2 - 1` (integer division) on start detect and `BAUDRATE - 1` after every sample. A sample fires when the counter is 0.
- **States:**
  - **IDLE:** when `rxs==0`, load the half-bit count and go to START.
  - **START:** on the sample, if `rxs==1` the start was a glitch; return to IDLE with no strobe. Otherwise clear the bit index and go to DATA.
  - **DATA:** on each sample, shift `rxs` into the MSB of an 8-bit shift register (shift right). After the 8th sample, go to STOP.
  - **STOP:** on the sample, if `rxs==1`, load `data` from the shift register, pulse `rcv`, and go to IDLE. If `rxs==0`, pulse `ferr`, leave `data` unchanged, and go to BREAK.
  - **BREAK:** stay until `rxs==1`, then go to IDLE. A held-low line never produces spurious bytes.
- **Back-to-back characters:** the return to IDLE happens mid-stop-bit. A start bit that immediately follows the stop bit is accepted with no gap.
- **Mutual exclusion:** `rcv` and `ferr` are never both 1 in the same cycle.
- **Reset values:** `rstn==0` in any state gives IDLE, counter 0, shift register 0, `data=0`, `rcv=0`, `ferr=0`, synchronizers 1. Reset mid-frame discards the partial byte. No strobe is emitted for that frame.

## Timing
- Start detect: the FSM leaves IDLE 2 cycles after `rx` falls (synchronizer delay).
- Sample points: start bit at `BAUDRATE/2` cycles after leaving IDLE; each later bit `BAUDRATE` cycles after the previous sample.
- Latency: `rcv`/`ferr` asserts `2 + BAUDRATE/2 + 9*BAUDRATE` cycles after the `rx` falling edge, ±1.
  - For 104, this is 990 cycles.
- Strobe width: exactly 1 cycle. `data` updates in the same cycle `rcv` rises.
- Throughput: one byte per `10*BAUDRATE` cycles, sustained.
- Clock tolerance: sampling at mid-bit tolerates ±4% clock mismatch between transmitter and receiver over 10 bits.

## Structure
- Baud divisor constants (`` `B115200 ``, `` `B9600 ``, …) stay in the shared baud include. The receiver adds no new global constants.
- State encodings are local parameters of `uart_rx`.
- One natural sub-module is `baudgen_rx`: a down-counter with a `clr` input that loads `M/2 - 1` or `M - 1` and outputs a 1-cycle `tick` at 0. The FSM drives `clr` and consumes `tick`.
- Target size is 150–250 lines total.

## Test plan
Use `BAUDRATE=104` throughout.
- **Loop-back:** connect the transmitter to `rx`, send 0x41 ('A'), 0x00, 0xFF. Required: 3 `rcv` pulses with `data` equal to 0x41, 0x00, 0xFF in order; `ferr` never asserted; latency 990±1 cycles from each start edge.
- **Glitch rejection:** drive `rx` low for 20 cycles, then high. Required: return to IDLE; no `rcv`, no `ferr`, `data` unchanged.
- **Framing error:** send 0x55 with the stop bit driven 0, then hold `rx` low for 3000 cycles, then release to 1. Required: one `ferr` pulse; `data` unchanged; no further strobes. A following 0x3C then yields `rcv` with `data=0x3C`.
- **Back-to-back:** send 0xA5, 0x5A, 0xC3 with zero idle between stop and start. Required: 3 `rcv` pulses spaced 1040±1 cycles apart, with the correct bytes.
- **Reset mid-frame:** assert `rstn=0` for 1 cycle during data bit 4 of 0x81, then send 0x7E. Required: no strobe for the aborted frame (`data` reads 0 after reset); the next `rcv` carries 0x7E.
- **Clock skew:** send 0x96 at bit periods of 100 and 108 cycles. Required: `data=0x96` with `rcv` in both cases.
